// File: rtl/tile_painter.sv
`default_nettype none
// ============================================================================
// Module      : tile_painter
// Description : Pixel-drawing responder for the 2x2 memory-game tile
//               controller. Stages tile/colour loads, queues draw commands
//               in a small FIFO and rasters each tile's pixels into the VGA
//               adapter. The tile area is cleared to black out of reset.
// Revision    : 1.0 - initial release
// ============================================================================
module tile_painter #(
    parameter int TILE_SIZE = 40,
    parameter int ORIGIN_X  = 40,
    parameter int ORIGIN_Y  = 20,
    parameter int DEPTH     = 4
) (
    input  logic       clock,
    input  logic       resetn,
    input  logic       ld_tile,
    input  logic       ld_flash,
    input  logic       ld_previous,
    input  logic [2:0] tile_num,
    input  logic       writeEnable,
    input  logic       counterEnable,
    output logic [7:0] x,
    output logic [6:0] y,
    output logic [2:0] colour,
    output logic       plot,
    output logic       drw,
    output logic       ovf
);

    // Counters must span the 2T-wide clear raster, not just one tile.
    localparam int c_cnt_w = (2 * TILE_SIZE > 1) ? $clog2(2 * TILE_SIZE) : 1;
    localparam int c_ptr_w = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    localparam logic [c_cnt_w-1:0] c_last_tile = c_cnt_w'(TILE_SIZE - 1);
    localparam logic [c_cnt_w-1:0] c_last_clr  = c_cnt_w'(2 * TILE_SIZE - 1);
    localparam logic [7:0]         c_org_x     = 8'(ORIGIN_X);
    localparam logic [6:0]         c_org_y     = 7'(ORIGIN_Y);
    localparam logic [7:0]         c_size_x    = 8'(TILE_SIZE);
    localparam logic [6:0]         c_size_y    = 7'(TILE_SIZE);
    localparam logic [2:0]         c_flash     = 3'b111;
    localparam logic [2:0]         c_rst_col   = 3'b100;

    typedef enum logic [1:0] {
        S_CLEAR = 2'd0,
        S_IDLE  = 2'd1,
        S_DRAW  = 2'd2
    } state_t;

    function automatic logic [2:0] base_colour(input logic [1:0] t);
        case (t)
            2'd0:    base_colour = 3'b100;
            2'd1:    base_colour = 3'b010;
            2'd2:    base_colour = 3'b001;
            default: base_colour = 3'b110;
        endcase
    endfunction

    state_t               r_state, w_state_nxt;
    logic [c_cnt_w-1:0]   r_cx, r_cy, w_cx_nxt, w_cy_nxt, w_cx_adv, w_cy_adv, w_lim;
    logic                 w_last_x, w_last;
    logic [1:0]           r_tile, w_tile_nxt;
    logic [7:0]           r_x, w_x_nxt, w_bx;
    logic [6:0]           r_y, w_y_nxt, w_by;
    logic [2:0]           r_colour, w_col_nxt;
    logic                 r_plot, w_plot_nxt;
    logic                 r_ovf;

    logic [1:0]           r_stage_tile, w_stage_tile_nxt;
    logic [2:0]           r_stage_col, w_stage_col_nxt;

    logic [4:0]           r_mem [DEPTH];
    logic [c_ptr_w-1:0]   r_wr_ptr, r_rd_ptr;
    logic [c_ptr_w:0]     r_count;
    logic                 w_start, w_full, w_empty, w_push, w_pop;
    logic [1:0]           w_head_tile;
    logic [2:0]           w_head_col;

    // Bit 2 of the tile index has no meaning on a 2x2 board.
    logic w_unused;
    assign w_unused = tile_num[2];

    assign w_start     = writeEnable & counterEnable;
    assign w_full      = (r_count == (c_ptr_w + 1)'(DEPTH));
    assign w_empty     = (r_count == '0);
    assign w_push      = w_start & ~w_full;
    assign w_head_tile = r_mem[r_rd_ptr][4:3];
    assign w_head_col  = r_mem[r_rd_ptr][2:0];

    assign w_lim    = (r_state == S_CLEAR) ? c_last_clr : c_last_tile;
    assign w_last_x = (r_cx == w_lim);
    assign w_last   = w_last_x && (r_cy == w_lim);
    assign w_cx_adv = w_last_x ? '0 : r_cx + c_cnt_w'(1);
    assign w_cy_adv = w_last_x ? r_cy + c_cnt_w'(1) : r_cy;

    assign x      = r_x;
    assign y      = r_y;
    assign colour = r_colour;
    assign plot   = r_plot;
    assign ovf    = r_ovf;
    assign drw    = (r_state == S_IDLE) & w_empty;

    // Staging register update; the next value doubles as the FIFO write data
    // so a load and start in the same cycle pushes the freshly loaded value.
    always_comb begin
        w_stage_tile_nxt = r_stage_tile;
        w_stage_col_nxt  = r_stage_col;
        if (ld_tile) begin
            w_stage_tile_nxt = tile_num[1:0];
            w_stage_col_nxt  = base_colour(tile_num[1:0]);
        end else if (ld_flash) begin
            w_stage_col_nxt  = c_flash;
        end else if (ld_previous) begin
            w_stage_col_nxt  = base_colour(r_stage_tile);
        end
    end

    // Raster FSM next-state and next pixel; counters hold the pixel shown now.
    always_comb begin
        w_state_nxt = r_state;
        w_cx_nxt    = r_cx;
        w_cy_nxt    = r_cy;
        w_tile_nxt  = r_tile;
        w_col_nxt   = r_colour;
        w_plot_nxt  = 1'b0;
        w_pop       = 1'b0;
        case (r_state)
            S_CLEAR: begin
                w_col_nxt = 3'b000;
                if (!r_plot) begin
                    // First cycle out of reset: present pixel (0,0).
                    w_plot_nxt = 1'b1;
                end else if (w_last) begin
                    w_state_nxt = S_IDLE;
                end else begin
                    w_plot_nxt = 1'b1;
                    w_cx_nxt   = w_cx_adv;
                    w_cy_nxt   = w_cy_adv;
                end
            end
            S_IDLE: begin
                if (!w_empty) begin
                    w_pop       = 1'b1;
                    w_state_nxt = S_DRAW;
                    w_cx_nxt    = '0;
                    w_cy_nxt    = '0;
                    w_tile_nxt  = w_head_tile;
                    w_col_nxt   = w_head_col;
                    w_plot_nxt  = 1'b1;
                end
            end
            S_DRAW: begin
                if (w_last) begin
                    if (!w_empty) begin
                        // Chain straight into the next tile with no gap.
                        w_pop      = 1'b1;
                        w_cx_nxt   = '0;
                        w_cy_nxt   = '0;
                        w_tile_nxt = w_head_tile;
                        w_col_nxt  = w_head_col;
                        w_plot_nxt = 1'b1;
                    end else begin
                        w_state_nxt = S_IDLE;
                    end
                end else begin
                    w_plot_nxt = 1'b1;
                    w_cx_nxt   = w_cx_adv;
                    w_cy_nxt   = w_cy_adv;
                end
            end
            default: begin
                w_state_nxt = S_CLEAR;
            end
        endcase

        if (r_state == S_CLEAR) begin
            w_bx = c_org_x;
            w_by = c_org_y;
        end else begin
            w_bx = c_org_x + (w_tile_nxt[0] ? c_size_x : 8'd0);
            w_by = c_org_y + (w_tile_nxt[1] ? c_size_y : 7'd0);
        end
        w_x_nxt = w_plot_nxt ? (w_bx + 8'(w_cx_nxt)) : r_x;
        w_y_nxt = w_plot_nxt ? (w_by + 7'(w_cy_nxt)) : r_y;
    end

    // State, counters, registered pixel outputs, staging and FIFO control.
    always_ff @(posedge clock) begin
        if (!resetn) begin
            r_state      <= S_CLEAR;
            r_cx         <= '0;
            r_cy         <= '0;
            r_tile       <= 2'd0;
            r_x          <= 8'd0;
            r_y          <= 7'd0;
            r_colour     <= 3'd0;
            r_plot       <= 1'b0;
            r_ovf        <= 1'b0;
            r_stage_tile <= 2'd0;
            r_stage_col  <= c_rst_col;
            r_wr_ptr     <= '0;
            r_rd_ptr     <= '0;
            r_count      <= '0;
        end else begin
            r_state      <= w_state_nxt;
            r_cx         <= w_cx_nxt;
            r_cy         <= w_cy_nxt;
            r_tile       <= w_tile_nxt;
            r_x          <= w_x_nxt;
            r_y          <= w_y_nxt;
            r_colour     <= w_col_nxt;
            r_plot       <= w_plot_nxt;
            r_stage_tile <= w_stage_tile_nxt;
            r_stage_col  <= w_stage_col_nxt;
            if (w_start && w_full) begin
                r_ovf <= 1'b1;
            end
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + c_ptr_w'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_ptr_w'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + (c_ptr_w + 1)'(1);
                2'b01:   r_count <= r_count - (c_ptr_w + 1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // FIFO storage; contents are don't-care until written, so no reset.
    always_ff @(posedge clock) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= {w_stage_tile_nxt, w_stage_col_nxt};
        end
    end

endmodule
`default_nettype wire

// File: doc/tile_painter.md
Name: tile_painter

Overview:
- Pixel-drawing responder for the 2x2 memory-game tile controller.
- Accepts the controller's load strobes (ld_tile/ld_flash/ld_previous + tile_num) and draw strobes (writeEnable/counterEnable).
- Queues draw commands, scans each tile's pixels into the VGA adapter (x, y, colour, plot), and returns drw when it can take the next load/draw.
- Sits between the graphics control FSM and the VGA adapter.

Parameters:
TILE_SIZE, 40, tile edge in pixels (square)
ORIGIN_X, 40, x of top-left tile; ORIGIN_X+2*TILE_SIZE <= 160
ORIGIN_Y, 20, y of top-left tile; ORIGIN_Y+2*TILE_SIZE <= 120
DEPTH, 4, draw-command FIFO depth (power of 2)

Ports:
clock  in  1  system clock
resetn  in  1  synchronous active-low reset
ld_tile  in  1  stage tile_num with its base colour
ld_flash  in  1  stage currently staged tile with colour white
ld_previous  in  1  stage currently staged tile with its base colour
tile_num  in  3  tile index; bit 2 ignored
writeEnable  in  1  draw request (start = writeEnable & counterEnable)
counterEnable  in  1  draw request qualifier
x  out  8  pixel x
y  out  7  pixel y
colour  out  3  pixel colour RGB
plot  out  1  pixel write strobe
drw  out  1  ready: engine idle, FIFO empty, clear done
ovf  out  1  sticky: start dropped because FIFO full

Behaviour:
- Reset: synchronous, active-low; clock is clock. On reset: x=0, y=0, colour=0, plot=0, drw=0, ovf=0. FIFO emptied, staging tile=0, staging colour=3'b100, state=CLEAR. Reset mid-draw aborts immediately; queued commands are lost.
- Tile geometry: tile t base_x = ORIGIN_X + (t[0] ? TILE_SIZE : 0); base_y = ORIGIN_Y + (t[1] ? TILE_SIZE : 0).
- Base palette: t0=3'b100, t1=3'b010, t2=3'b001, t3=3'b110. Flash=3'b111.
- Staging register: {tile, colour}, updated every cycle a load strobe is high, including while busy.
  - Priority: ld_tile > ld_flash > ld_previous.
  - ld_flash and ld_previous keep the staged tile.
- Start: pushes {tile, colour} into the FIFO.
  - If a load occurs in the same cycle, the newly loaded value is pushed (bypass).
  - If the FIFO is full, the push is dropped and ovf is set; ovf clears only on reset.
- States:
  - CLEAR: raster the 2T x 2T tile area from (ORIGIN_X, ORIGIN_Y), row-major, colour 0, plot=1 each cycle. Goes to IDLE after the last pixel.
  - IDLE: plot=0. If the FIFO is non-empty, pop and go to DRAW.
  - DRAW: counters cx, cy run 0..T-1, row-major (cx fastest).
    - Each cycle: x=base_x+cx, y=base_y+cy, colour=popped colour, plot=1.
    - On the last pixel (cx=cy=T-1): if the FIFO is non-empty, pop and continue into DRAW with no gap cycle; else go to IDLE.
- Starts received during CLEAR are queued and drawn after CLEAR completes.
- Outputs are registered.
- Latency: start sampled in cycle N with the engine idle and FIFO empty gives first plot in N+2, last plot in N+1+T², and drw=1 in N+2+T².
- drw is combinational from registered state: (state==IDLE) & FIFO empty.
- Simultaneous push and pop: both occur, and the occupancy count is unchanged.
- Counter wrap: cx resets to 0 and cy increments when cx=T-1. No x/y overflow given the parameter constraints.
- writeEnable without counterEnable, or counterEnable alone: ignored.

Test Plan:
- Reset then idle (T=4): 64 consecutive plot cycles, colour 0, x 40..47, y 20..27 → drw=1 on the following cycle, ovf=0.
- ld_tile tile_num=3 then start (T=4): 16 plots, x 44..47, y 24..27, colour 110. drw low throughout, high at N+18.
- Bootup burst: load t0, start, load t1, start, load t2, start, load t3, start on consecutive cycles → 64 back-to-back plots in tile order 0,1,2,3 with correct colours, no gap, ovf=0.
- Flash/restore: ld_tile 1, start, wait drw, ld_flash, start, wait drw, ld_previous, start → three 16-pixel scans of tile 1 coloured 010, 111, 010.
- Overflow (DEPTH=4): 6 starts while the engine is busy → 4 queued plus 1 active drawn, 1 dropped, ovf=1 and stays 1 until reset.
- Reset asserted mid-DRAW with a queued command → next cycle plot=0, drw=0. The CLEAR scan restarts from (40,20), and the queued command is never drawn.
